// File: rtl/hsv_core_pkg.sv
// Shared core definitions: CSR op encoding, exception causes and the CSR
// write-encoding helper used by the Zicsr access sequencer.
package hsv_core_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    localparam logic [4:0] EXC_ILLEGAL_INSN = 5'd2;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic [CSR_DATA_W-1:0] data;
        logic [CSR_DATA_W-1:0] biten;
    } csr_wr_t;

    // Set/clear become bit-enabled writes of all-ones/all-zeros so the register
    // block only ever sees one masked-write primitive.
    function automatic csr_wr_t csr_wr_encode(input csr_op_e op,
                                              input logic [CSR_DATA_W-1:0] src);
        csr_wr_t w;
        w.data  = '0;
        w.biten = '0;
        case (op)
            CSR_OP_RW: begin
                w.data  = src;
                w.biten = '1;
            end
            CSR_OP_RS: begin
                w.data  = '1;
                w.biten = src;
            end
            CSR_OP_RC: begin
                w.data  = '0;
                w.biten = src;
            end
            default: begin
                w.data  = '0;
                w.biten = '0;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/hsv_core_ctrlstatus_access_if.sv
// Issue, CSR-bus and result signals of the CSR access sequencer.
// slave is the sequencer's view; master is the surrounding core/bench view.
interface hsv_core_ctrlstatus_access_if;

    logic                                   in_valid;
    logic                                   in_ready;
    logic [1:0]                             in_op;
    logic [hsv_core_pkg::CSR_ADDR_W-1:0]    in_addr;
    logic [hsv_core_pkg::CSR_DATA_W-1:0]    in_src;
    logic                                   in_rd_zero;
    logic                                   in_src_zero;
    logic [1:0]                             in_priv;

    logic                                   csr_req;
    logic                                   csr_req_is_wr;
    logic [hsv_core_pkg::CSR_ADDR_W-1:0]    csr_addr;
    logic [hsv_core_pkg::CSR_DATA_W-1:0]    csr_wr_data;
    logic [hsv_core_pkg::CSR_DATA_W-1:0]    csr_wr_biten;
    logic                                   csr_rd_ack;
    logic                                   csr_wr_ack;
    logic [hsv_core_pkg::CSR_DATA_W-1:0]    csr_rd_data;

    logic                                   out_valid;
    logic                                   out_ready;
    logic [hsv_core_pkg::CSR_DATA_W-1:0]    out_data;
    logic                                   out_write_rd;
    logic                                   out_exception;
    logic [4:0]                             out_cause;
    logic                                   ctrl_commit;

    modport slave (
        input  in_valid, in_op, in_addr, in_src, in_rd_zero, in_src_zero, in_priv,
        output in_ready,
        output csr_req, csr_req_is_wr, csr_addr, csr_wr_data, csr_wr_biten,
        input  csr_rd_ack, csr_wr_ack, csr_rd_data,
        output out_valid, out_data, out_write_rd, out_exception, out_cause, ctrl_commit,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_addr, in_src, in_rd_zero, in_src_zero, in_priv,
        input  in_ready,
        input  csr_req, csr_req_is_wr, csr_addr, csr_wr_data, csr_wr_biten,
        output csr_rd_ack, csr_wr_ack, csr_rd_data,
        input  out_valid, out_data, out_write_rd, out_exception, out_cause, ctrl_commit,
        output out_ready
    );

endinterface

// File: rtl/hsv_core_ctrlstatus_access.sv
// Zicsr access sequencer: legality check, optional read, optional masked write,
// then a held result and a retire pulse for non-excepting operations.
module hsv_core_ctrlstatus_access
    import hsv_core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_core,
    input  logic                        rst_core_n,
    hsv_core_ctrlstatus_access_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    state_e                 state;
    state_e                 state_nxt;
    logic [CNT_W-1:0]       cnt;

    logic                   need_rd_q;
    logic                   need_wr_q;
    logic                   rd_zero_q;
    logic                   exc_q;
    logic [CSR_ADDR_W-1:0]  addr_q;
    logic [CSR_DATA_W-1:0]  wr_data_q;
    logic [CSR_DATA_W-1:0]  biten_q;
    logic [CSR_DATA_W-1:0]  rd_data_q;

    csr_op_e                op_in;
    logic                   lat_need_wr;
    logic                   lat_need_rd;
    logic                   lat_illegal;
    csr_wr_t                lat_wr;

    logic                   accept;
    logic                   cnt_clr;
    logic                   rd_capture;
    logic                   timeout;

    // Decode of the operation being offered; only meaningful on accept.
    always_comb begin
        op_in       = csr_op_e'(bus.in_op);
        lat_need_wr = (op_in == CSR_OP_RW) ||
                      (((op_in == CSR_OP_RS) || (op_in == CSR_OP_RC)) && !bus.in_src_zero);
        lat_need_rd = !((op_in == CSR_OP_RW) && bus.in_rd_zero);
        lat_illegal = (op_in == CSR_OP_RSVD) ||
                      (bus.in_addr[9:8] > bus.in_priv) ||
                      (lat_need_wr && (bus.in_addr[11:10] == 2'b11));
        lat_wr      = csr_wr_encode(op_in, bus.in_src);
    end

    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A skipped read falls straight through to WRITE at accept, so write-only
    // operations see the same latency as read-only ones.
    always_comb begin
        state_nxt         = state;
        bus.csr_req       = 1'b0;
        bus.csr_req_is_wr = 1'b0;
        cnt_clr           = 1'b0;
        rd_capture        = 1'b0;
        timeout           = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_clr = 1'b1;
                    if (lat_illegal) begin
                        state_nxt = RESP;
                    end else if (lat_need_rd) begin
                        state_nxt = READ;
                    end else if (lat_need_wr) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            READ: begin
                bus.csr_req = 1'b1;
                if (bus.csr_rd_ack) begin
                    rd_capture = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nxt  = need_wr_q ? WRITE : RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WRITE: begin
                bus.csr_req       = 1'b1;
                bus.csr_req_is_wr = 1'b1;
                if (bus.csr_wr_ack) begin
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            cnt       <= '0;
            need_rd_q <= 1'b0;
            need_wr_q <= 1'b0;
            rd_zero_q <= 1'b0;
            exc_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            biten_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if ((state == READ) || (state == WRITE)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                need_rd_q <= lat_need_rd;
                need_wr_q <= lat_need_wr;
                rd_zero_q <= bus.in_rd_zero;
                exc_q     <= lat_illegal;
                addr_q    <= bus.in_addr;
                wr_data_q <= lat_illegal ? '0 : lat_wr.data;
                biten_q   <= lat_illegal ? '0 : lat_wr.biten;
                rd_data_q <= '0;
            end

            if (rd_capture) begin
                rd_data_q <= bus.csr_rd_data;
            end

            // An aborted access reports no old value, even if the read succeeded.
            if (timeout) begin
                exc_q     <= 1'b1;
                rd_data_q <= '0;
            end
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.csr_addr      = addr_q;
    assign bus.csr_wr_data   = wr_data_q;
    assign bus.csr_wr_biten  = biten_q;

    assign bus.out_valid     = (state == RESP);
    assign bus.out_data      = rd_data_q;
    assign bus.out_exception = exc_q && (state == RESP);
    assign bus.out_cause     = (exc_q && (state == RESP)) ? EXC_ILLEGAL_INSN : 5'd0;
    assign bus.out_write_rd  = (state == RESP) && !rd_zero_q && !exc_q;
    assign bus.ctrl_commit   = (state == RESP) && bus.out_ready && !exc_q;

    // need_rd_q is kept for visibility of the decoded operation; READ is only
    // entered when it is set.
    logic unused_need_rd;
    assign unused_need_rd = need_rd_q;

endmodule

// File: tb/tb_hsv_core_ctrlstatus_access.sv
// Directed bench for the CSR access sequencer with a scoreboard of expected results.
module tb_hsv_core_ctrlstatus_access;
    import hsv_core_pkg::*;

    localparam logic [11:0] NOACK_ADDR = 12'h7C0;
    localparam logic [11:0] NOWR_ADDR  = 12'h7C1;

    typedef struct packed {
        logic [31:0] data;
        logic        write_rd;
        logic        exc;
        logic [4:0]  cause;
    } exp_t;

    logic clk_core = 1'b0;
    logic rst_core_n = 1'b0;
    logic [31:0] rd_value = 32'h0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int req_cycles = 0;
    int rd_acks = 0;
    int wr_acks = 0;
    int commits = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_biten = 32'h0;
    logic [11:0] last_waddr = 12'h0;

    hsv_core_ctrlstatus_access_if bus ();

    hsv_core_ctrlstatus_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .bus        (bus)
    );

    always #5 clk_core = ~clk_core;

    // Register-block model: same-cycle acks, except two addresses that stall.
    always_comb begin
        bus.csr_rd_ack  = bus.csr_req && !bus.csr_req_is_wr && (bus.csr_addr != NOACK_ADDR);
        bus.csr_wr_ack  = bus.csr_req && bus.csr_req_is_wr &&
                          (bus.csr_addr != NOACK_ADDR) && (bus.csr_addr != NOWR_ADDR);
        bus.csr_rd_data = bus.csr_rd_ack ? rd_value : 32'h0;
    end

    always @(posedge clk_core) begin
        if (bus.csr_req) req_cycles <= req_cycles + 1;
        if (bus.csr_rd_ack) rd_acks <= rd_acks + 1;
        if (bus.csr_wr_ack) begin
            wr_acks    <= wr_acks + 1;
            last_wdata <= bus.csr_wr_data;
            last_biten <= bus.csr_wr_biten;
            last_waddr <= bus.csr_addr;
        end
        if (bus.ctrl_commit) commits <= commits + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] src, input logic rd_zero, input logic src_zero,
                          input logic [1:0] priv, input logic [31:0] rdv,
                          input logic [31:0] exp_data, input logic exp_exc, input int exp_lat,
                          input int exp_reqs, input int exp_rds, input int exp_wrs,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_biten,
                          input int bp);
        exp_t e;
        exp_t want;
        int lat;
        int rq0, rd0, wr0, cm0;
        logic [31:0] held;
        @(negedge clk_core);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        rd_value        = rdv;
        bus.in_op       = op;
        bus.in_addr     = addr;
        bus.in_src      = src;
        bus.in_rd_zero  = rd_zero;
        bus.in_src_zero = src_zero;
        bus.in_priv     = priv;
        bus.in_valid    = 1'b1;
        e.data     = exp_data;
        e.write_rd = !rd_zero && !exp_exc;
        e.exc      = exp_exc;
        e.cause    = exp_exc ? 5'd2 : 5'd0;
        sb.push_back(e);
        rq0 = req_cycles; rd0 = rd_acks; wr0 = wr_acks; cm0 = commits;
        @(posedge clk_core);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk_core);
            lat++;
        end while (!bus.out_valid && lat < 60);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        want = sb.pop_front();
        chk({tag, " out_data"}, bus.out_data, want.data);
        chk({tag, " out_write_rd"}, 32'(bus.out_write_rd), 32'(want.write_rd));
        chk({tag, " out_exception"}, 32'(bus.out_exception), 32'(want.exc));
        chk({tag, " out_cause"}, 32'(bus.out_cause), 32'(want.cause));
        chk({tag, " req_cycles"}, 32'(req_cycles - rq0), 32'(exp_reqs));
        chk({tag, " rd_acks"}, 32'(rd_acks - rd0), 32'(exp_rds));
        chk({tag, " wr_acks"}, 32'(wr_acks - wr0), 32'(exp_wrs));
        if (exp_wrs > 0) begin
            chk({tag, " wr_data"}, last_wdata, exp_wdata);
            chk({tag, " wr_biten"}, last_biten, exp_biten);
            chk({tag, " wr_addr"}, 32'(last_waddr), 32'(addr));
        end
        held = bus.out_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk_core);
            chk({tag, " bp out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " bp out_data"}, bus.out_data, held);
            chk({tag, " bp commit"}, 32'(bus.ctrl_commit), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk({tag, " commit pulse"}, 32'(bus.ctrl_commit), 32'(!exp_exc));
        @(posedge clk_core);
        #1 bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " commits"}, 32'(commits - cm0), 32'(!exp_exc));
    endtask

    initial begin
        int n;
        int cm0;
        bus.in_valid    = 1'b0;
        bus.in_op       = 2'b00;
        bus.in_addr     = 12'h0;
        bus.in_src      = 32'h0;
        bus.in_rd_zero  = 1'b0;
        bus.in_src_zero = 1'b0;
        bus.in_priv     = 2'd3;
        bus.out_ready   = 1'b0;

        repeat (2) @(negedge clk_core);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst csr_req", 32'(bus.csr_req), 32'd0);
        chk("rst commit", 32'(bus.ctrl_commit), 32'd0);
        chk("rst out_data", bus.out_data, 32'h0);
        chk("rst out_write_rd", 32'(bus.out_write_rd), 32'd0);
        chk("rst out_cause", 32'(bus.out_cause), 32'd0);
        chk("rst csr_wr_data", bus.csr_wr_data, 32'h0);
        rst_core_n = 1'b1;

        //     tag          op         addr     src          rdz   srcz  pv  rdv           data          exc lat rq rd wr wdata         biten         bp
        run_op("rw_mcycle", CSR_OP_RW, 12'hB00, 32'h1234,    1'b0, 1'b0, 3, 32'h50,      32'h50,       0,  3,  2, 1, 1, 32'h1234,     32'hFFFFFFFF, 0);
        run_op("rs_minstr", CSR_OP_RS, 12'hB02, 32'h0,       1'b0, 1'b1, 3, 32'h123,     32'h123,      0,  2,  1, 1, 0, 32'h0,        32'h0,        0);
        run_op("rc_mcycle", CSR_OP_RC, 12'hB00, 32'h0F,      1'b0, 1'b0, 3, 32'hFF,      32'hFF,       0,  3,  2, 1, 1, 32'h0,        32'h0F,       0);
        run_op("rs_mstat",  CSR_OP_RS, 12'h300, 32'hC0,      1'b0, 1'b0, 3, 32'h1800,    32'h1800,     0,  3,  2, 1, 1, 32'hFFFFFFFF, 32'hC0,       0);
        run_op("rw_rdx0",   CSR_OP_RW, 12'hB00, 32'hAA,      1'b1, 1'b0, 3, 32'h77,      32'h0,        0,  2,  1, 0, 1, 32'hAA,       32'hFFFFFFFF, 0);
        run_op("rs_cycle",  CSR_OP_RS, 12'hC00, 32'h0,       1'b0, 1'b1, 0, 32'hCAFE,    32'hCAFE,     0,  2,  1, 1, 0, 32'h0,        32'h0,        0);
        run_op("ill_ro",    CSR_OP_RW, 12'hC00, 32'h5,       1'b0, 1'b0, 3, 32'h9,       32'h0,        1,  1,  0, 0, 0, 32'h0,        32'h0,        0);
        run_op("ill_priv",  CSR_OP_RS, 12'hB00, 32'h0,       1'b0, 1'b1, 0, 32'h9,       32'h0,        1,  1,  0, 0, 0, 32'h0,        32'h0,        0);
        run_op("ill_rsvd",  2'b00,     12'h300, 32'h1,       1'b0, 1'b0, 3, 32'h9,       32'h0,        1,  1,  0, 0, 0, 32'h0,        32'h0,        0);
        run_op("to_read",   CSR_OP_RW, NOACK_ADDR, 32'h5,    1'b0, 1'b0, 3, 32'h9,       32'h0,        1, 17, 16, 0, 0, 32'h0,        32'h0,        0);
        run_op("to_write",  CSR_OP_RW, NOWR_ADDR,  32'h7,    1'b0, 1'b0, 3, 32'h99,      32'h0,        1, 18, 17, 1, 0, 32'h0,        32'h0,        0);
        run_op("bp_rw",     CSR_OP_RW, 12'hB00, 32'h1234,    1'b0, 1'b0, 3, 32'h50,      32'h50,       0,  3,  2, 1, 1, 32'h1234,     32'hFFFFFFFF, 5);

        // Reset while a write request is outstanding.
        @(negedge clk_core);
        bus.in_op       = CSR_OP_RW;
        bus.in_addr     = NOWR_ADDR;
        bus.in_src      = 32'h3;
        bus.in_rd_zero  = 1'b0;
        bus.in_src_zero = 1'b0;
        bus.in_priv     = 2'd3;
        bus.in_valid    = 1'b1;
        @(posedge clk_core);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk_core);
            n++;
        end while (!(bus.csr_req && bus.csr_req_is_wr) && n < 10);
        chk("rstw in WRITE", 32'(bus.csr_req && bus.csr_req_is_wr), 32'd1);
        cm0 = commits;
        #2 rst_core_n = 1'b0;
        #1;
        chk("rstw csr_req async", 32'(bus.csr_req), 32'd0);
        @(negedge clk_core);
        rst_core_n = 1'b1;
        @(negedge clk_core);
        chk("rstw in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstw out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstw csr_req", 32'(bus.csr_req), 32'd0);
        chk("rstw no commit", 32'(commits - cm0), 32'd0);

        run_op("after_rst", CSR_OP_RC, 12'h300, 32'h8,       1'b0, 1'b0, 3, 32'h1808,    32'h1808,     0,  3,  2, 1, 1, 32'h0,        32'h8,        0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
